// File: rtl/t02_wishbone_subordinate.sv
// Wishbone classic-cycle subordinate backed by a word-addressed register memory,
// with programmable wait states and byte lanes. Define T02_WB_SUB_ERR_EN to add ERR_O.
module t02_wishbone_subordinate #(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          DEPTH_WORDS = 32,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
`ifdef T02_WB_SUB_ERR_EN
    output logic        ERR_O,
`endif
    output logic [31:0] DAT_O,
    output logic        ACK_O
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR  = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               capture, wr_en;

    logic [IDX_W-1:0]   idx_q;
    logic               inr_q, we_q;
    logic [3:0]         sel_q;
    logic [31:0]        dat_q;
    logic [31:0]        mem [DEPTH_WORDS];

    // Range check done on 33 bits so a region ending at 2^32 does not wrap.
    logic [31:0] offset;
    logic        in_range;
    assign offset   = ADR_I - ADDR_BASE;
    assign in_range = ({1'b0, ADR_I} >= {1'b0, ADDR_BASE}) && ({1'b0, ADR_I} < END_ADDR);

    logic unused_ok;
    assign unused_ok = &{1'b0, offset[1:0], offset[31:IDX_W+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CYC_I && STB_I) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!CYC_I)            state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_ACK;
                else                    cnt_d   = cnt_q - 4'd1;
            end
            S_ACK: begin
                state_d = S_IDLE;
                wr_en   = we_q && inr_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            inr_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q <= offset[IDX_W+1:2];
                inr_q <= in_range;
                we_q  <= WE_I;
                sel_q <= SEL_I;
                dat_q <= DAT_I;
            end
            // Write commits on the edge that ends the ACK cycle.
            if (wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
            end
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign DAT_O = (state_q == S_ACK && !we_q && inr_q) ? mem[idx_q] : 32'h0;
`ifdef T02_WB_SUB_ERR_EN
    assign ACK_O = (state_q == S_ACK) && inr_q;
    assign ERR_O = (state_q == S_ACK) && !inr_q;
`else
    assign ACK_O = (state_q == S_ACK);
`endif

endmodule

// File: doc/t02_wishbone_subordinate.md
Name: t02_wishbone_subordinate

Overview:
- Wishbone classic-cycle responder (subordinate). Serves single 32-bit reads and writes from the team's Wishbone manager against an internal word-addressed register memory.
- Complements the existing CPU-side manager and replaces the external bus model in team-level simulation.
- Supports programmable wait states and byte lane selects.

Parameters:
- ADDR_BASE, 32'h3000_0000, byte address of word 0.
- DEPTH_WORDS, 32, number of 32-bit words; power of two, 2..256.
- WAIT_CYCLES, 1, wait states inserted between request capture and ACK_O; range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ADR_I  input  32  byte address from the manager.
- DAT_I  input  32  write data.
- SEL_I  input  4  byte lane enables; bit n enables DAT_I[8n+7:8n].
- WE_I  input  1  1 = write, 0 = read.
- STB_I  input  1  strobe.
- CYC_I  input  1  bus cycle valid.
- DAT_O  output  32  read data; valid only while ACK_O=1.
- ACK_O  output  1  transfer-complete pulse.

Behaviour:
- Reset: every memory word = 0, DAT_O = 0, ACK_O = 0, state = IDLE, wait counter = 0. Reset takes effect immediately at any time, including mid-transaction. A write whose ACK cycle has not been reached is discarded.
- Decode:
  - in_range = (ADR_I >= ADDR_BASE) && (ADR_I < ADDR_BASE + 4*DEPTH_WORDS).
  - index = (ADR_I - ADDR_BASE) >> 2.
  - ADR_I[1:0] is ignored.
  - The 33-bit comparison must not wrap when ADDR_BASE + 4*DEPTH_WORDS overflows 2^32.
- IDLE:
  - When CYC_I & STB_I: capture index, in_range, WE_I, SEL_I and DAT_I into registers.
  - If WAIT_CYCLES = 0, go to ACK; otherwise load the counter with WAIT_CYCLES - 1 and go to WAIT.
- WAIT:
  - If CYC_I = 0, abort to IDLE: no write, no ACK.
  - Else if counter = 0, go to ACK; else decrement the counter.
- ACK:
  - ACK_O = 1 for exactly one cycle. The state always returns to IDLE next cycle, so there is never back-to-back ACK.
  - Write, in range: on this edge, update each byte lane whose SEL bit is set. SEL = 0 completes with no change.
  - Read, in range: DAT_O = mem[index] during this cycle. Bytes not selected by SEL are still driven; the manager masks them.
  - Out-of-range access (feature disabled): write ignored, DAT_O = 0, ACK_O still pulses.
  - When not in ACK: DAT_O = 0 and ACK_O = 0.
- Latency: from the edge sampling CYC_I&STB_I to ACK_O high is WAIT_CYCLES+1 cycles. A new request can be accepted, at the earliest, on the cycle after ACK.
- Bus inputs are ignored outside IDLE. Changes of ADR_I, DAT_I or SEL_I after capture have no effect.

Optional Feature:
- Macro: T02_WB_SUB_ERR_EN.
- Defined:
  - Adds output port ERR_O (1 bit, reset 0).
  - An out-of-range access completes with ERR_O = 1 and ACK_O = 0 for one cycle, at the same timing as ACK.
  - The memory is untouched and DAT_O = 0.
  - ACK_O and ERR_O are never high together.
- Not defined:
  - No ERR_O port.
  - Out-of-range accesses ACK normally, as described in Behaviour.

Test Plan:
- Reset then read: rst pulse, then read 0x3000_0004 with WAIT_CYCLES=1 -> ACK_O high on the 2nd cycle after the request, DAT_O = 0x0000_0000; ACK_O is high for exactly one cycle.
- Full write then read: write 0xDEAD_BEEF to 0x3000_0008 with SEL=4'hF, then read it back -> DAT_O = 0xDEAD_BEEF. Reading 0x3000_000B returns the same word.
- Byte lanes: word preloaded with 0x1122_3344, write 0xAABB_CCDD with SEL=4'b0101 -> readback is 0x11BB_33DD.
- Abort: start a write of 0x5555_5555 to 0x3000_0000 with WAIT_CYCLES=3, drop CYC_I after 1 cycle -> no ACK_O, and readback returns the prior value 0.
- Out of range: write then read 0x3000_0080 (DEPTH_WORDS=32) -> ACK_O pulses and DAT_O = 0. With T02_WB_SUB_ERR_EN defined: ERR_O pulses, ACK_O stays 0. In both cases word 0 is unchanged.
- Reset mid-ACK plus zero-wait: assert rst during a write's WAIT state -> word unchanged and ACK_O = 0 immediately. With WAIT_CYCLES=0, back-to-back requests held on STB_I -> ACK on alternating cycles, each write applied once.
